// File: rtl/schaltung_monitor_pkg.sv
// Shared definitions for the schaltung_monitor slice: vector width and the
// period-meter state type.
package schaltung_monitor_pkg;

    localparam int unsigned VEC_W = 3;

    typedef logic [VEC_W-1:0] vec_t;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ARM     = 2'd1,
        MEASURE = 2'd2,
        LOCKED  = 2'd3
    } pm_state_t;

endpackage

// File: rtl/schaltung_monitor_if.sv
// Signal bundle between the sequence-generator side (master) and the monitor (slave).
interface schaltung_monitor_if #(
    parameter int unsigned CNT_W = 8,
    parameter int unsigned PER_W = 4
);
    logic             en;
    logic             start;
    logic             a, b, c;
    logic             d, e, f;
    logic             match;
    logic [CNT_W-1:0] mismatch_cnt;
    logic [PER_W-1:0] per_nb;
    logic             per_nb_valid;
    logic [PER_W-1:0] per_b;
    logic             per_b_valid;
    logic             alarm;

    modport master (
        output en, start, a, b, c, d, e, f,
        input  match, mismatch_cnt, per_nb, per_nb_valid, per_b, per_b_valid, alarm
    );

    modport slave (
        input  en, start, a, b, c, d, e, f,
        output match, mismatch_cnt, per_nb, per_nb_valid, per_b, per_b_valid, alarm
    );
endinterface

// File: rtl/schaltung_monitor_period_meter.sv
// period_meter: measures how many enabled cycles a 3-bit vector takes to recur
// after being armed by start; reports 0 on timeout at 2**PER_W-1.
module period_meter
    import schaltung_monitor_pkg::*;
#(
    parameter int unsigned PER_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             start,
    input  logic [VEC_W-1:0] vec,
    output logic [PER_W-1:0] period,
    output logic             valid
);

    localparam logic [PER_W-1:0] CNT_MAX = '1;

    pm_state_t        state;
    vec_t             ref_q;
    logic [PER_W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            ref_q  <= '0;
            cnt    <= '0;
            period <= '0;
            valid  <= 1'b0;
        end else if (start) begin
            // the start-cycle sample is deliberately ignored; ARM takes the next enabled one
            state  <= ARM;
            cnt    <= '0;
            period <= '0;
            valid  <= 1'b0;
        end else if (en) begin
            case (state)
                IDLE: ;
                ARM: begin
                    ref_q <= vec;
                    cnt   <= PER_W'(1);
                    state <= MEASURE;
                end
                MEASURE: begin
                    if (vec == ref_q) begin
                        period <= cnt;
                        valid  <= 1'b1;
                        state  <= LOCKED;
                    end else if (cnt == CNT_MAX) begin
                        period <= '0;
                        valid  <= 1'b1;
                        state  <= LOCKED;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                LOCKED: ;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: rtl/schaltung_monitor.sv
// Checker comparing the NB {a,b,c} and B {d,e,f} generator channels: match flag,
// saturating mismatch counter, per-channel period. Optional alarm: `define MON_ALARM_EN.
module schaltung_monitor
    import schaltung_monitor_pkg::*;
#(
    parameter int unsigned CNT_W        = 8,
    parameter int unsigned PER_W        = 4,
    parameter int unsigned ALARM_THRESH = 16
) (
    input logic                clk,
    input logic                rst,
    schaltung_monitor_if.slave mon
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    vec_t             nb_vec, b_vec;
    logic             differ;
    logic             match_q;
    logic [CNT_W-1:0] cnt_q, cnt_nxt;
    logic [PER_W-1:0] per_nb, per_b;
    logic             per_nb_valid, per_b_valid;

    assign nb_vec = {mon.a, mon.b, mon.c};
    assign b_vec  = {mon.d, mon.e, mon.f};
    assign differ = (nb_vec != b_vec);

    always_comb begin
        cnt_nxt = cnt_q;
        if (differ && cnt_q != CNT_MAX)
            cnt_nxt = cnt_q + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst || mon.start) begin
            match_q <= 1'b0;
            cnt_q   <= '0;
        end else if (mon.en) begin
            match_q <= ~differ;
            cnt_q   <= cnt_nxt;
        end
    end

`ifdef MON_ALARM_EN
    logic alarm_q;

    always_ff @(posedge clk) begin
        if (rst || mon.start)
            alarm_q <= 1'b0;
        else if (mon.en && (32'(cnt_nxt) >= ALARM_THRESH))
            alarm_q <= 1'b1;
    end

    assign mon.alarm = alarm_q;
`else
    // threshold is only meaningful in the alarm build; output folds to constant 0
    assign mon.alarm = 1'b0 & (ALARM_THRESH != 0);
`endif

    period_meter #(.PER_W(PER_W)) u_per_nb (
        .clk    (clk),
        .rst    (rst),
        .en     (mon.en),
        .start  (mon.start),
        .vec    (nb_vec),
        .period (per_nb),
        .valid  (per_nb_valid)
    );

    period_meter #(.PER_W(PER_W)) u_per_b (
        .clk    (clk),
        .rst    (rst),
        .en     (mon.en),
        .start  (mon.start),
        .vec    (b_vec),
        .period (per_b),
        .valid  (per_b_valid)
    );

    assign mon.match        = match_q;
    assign mon.mismatch_cnt = cnt_q;
    assign mon.per_nb       = per_nb;
    assign mon.per_nb_valid = per_nb_valid;
    assign mon.per_b        = per_b;
    assign mon.per_b_valid  = per_b_valid;

endmodule
